// File: rtl/accel_bus_master.sv
// Bus master that moves one accelerator command through a register-mapped peripheral:
// write A, B and opcode, wait a fixed settle time, read both result bytes, then hand back the result.
module accel_bus_master #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [3:0]  bus_address,
  output logic        bus_write,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        busy,
  output logic [7:0]  done_count
);

  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_A   = 3'd1,
    S_WR_B   = 3'd2,
    S_WR_OP  = 3'd3,
    S_SETTLE = 3'd4,
    S_RD_LO  = 3'd5,
    S_RD_HI  = 3'd6,
    S_RESP   = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_b;
  logic [2:0]  r_op;
  logic [3:0]  r_settle_cnt;
  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic        r_busy;
  logic [15:0] r_rsp_result;
  logic [7:0]  r_done_count;
  logic [3:0]  r_bus_address;
  logic        r_bus_write;
  logic [7:0]  r_bus_wdata;
  logic        w_cmd_hs;
  logic        w_rsp_hs;
  logic [3:0]  w_bus_address;
  logic        w_bus_write;
  logic [7:0]  w_bus_wdata;

  assign w_cmd_hs = cmd_valid & r_cmd_ready;
  assign w_rsp_hs = r_rsp_valid & rsp_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_hs) begin
          w_state_nxt = S_WR_A;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WR_A:  w_state_nxt = S_WR_B;
      S_WR_B:  w_state_nxt = S_WR_OP;
      S_WR_OP: begin
        if (SETTLE_CYCLES == 0) begin
          w_state_nxt = S_RD_LO;
        end else begin
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_settle_cnt == SETTLE_LAST) begin
          w_state_nxt = S_RD_LO;
        end else begin
          w_state_nxt = S_SETTLE;
        end
      end
      S_RD_LO: w_state_nxt = S_RD_HI;
      S_RD_HI: w_state_nxt = S_RESP;
      S_RESP: begin
        if (w_rsp_hs) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus fields are decoded from the next state and registered, so they are stable for the whole cycle.
  // WR_A is only entered through a command handshake, so cmd_a is the live operand there.
  always_comb begin
    w_bus_address = 4'hF;
    w_bus_write   = 1'b0;
    w_bus_wdata   = 8'h00;
    case (w_state_nxt)
      S_WR_A: begin
        w_bus_address = 4'h0;
        w_bus_write   = 1'b1;
        w_bus_wdata   = cmd_a;
      end
      S_WR_B: begin
        w_bus_address = 4'h1;
        w_bus_write   = 1'b1;
        w_bus_wdata   = r_b;
      end
      S_WR_OP: begin
        w_bus_address = 4'h4;
        w_bus_write   = 1'b1;
        w_bus_wdata   = {5'b00000, r_op};
      end
      S_SETTLE, S_RD_LO: w_bus_address = 4'h5;
      S_RD_HI:           w_bus_address = 4'h6;
      default: begin
        w_bus_address = 4'hF;
        w_bus_write   = 1'b0;
        w_bus_wdata   = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_settle_cnt  <= 4'd0;
      r_b           <= 8'h00;
      r_op          <= 3'd0;
      r_cmd_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_bus_address <= 4'hF;
      r_bus_write   <= 1'b0;
      r_bus_wdata   <= 8'h00;
    end else begin
      r_state       <= w_state_nxt;
      r_cmd_ready   <= (w_state_nxt == S_IDLE);
      r_rsp_valid   <= (w_state_nxt == S_RESP);
      r_busy        <= (w_state_nxt != S_IDLE);
      r_bus_address <= w_bus_address;
      r_bus_write   <= w_bus_write;
      r_bus_wdata   <= w_bus_wdata;
      if (r_state == S_SETTLE) begin
        r_settle_cnt <= r_settle_cnt + 4'd1;
      end else begin
        r_settle_cnt <= 4'd0;
      end
      if (w_cmd_hs) begin
        r_b  <= cmd_b;
        r_op <= cmd_op;
      end
    end
  end

  // Result bytes are sampled at the edge that ends each read cycle and kept until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_result <= 16'h0000;
      r_done_count <= 8'h00;
    end else begin
      if (r_state == S_RD_LO) begin
        r_rsp_result[7:0] <= bus_rdata;
      end
      if (r_state == S_RD_HI) begin
        r_rsp_result[15:8] <= bus_rdata;
      end
      if (w_rsp_hs) begin
        r_done_count <= r_done_count + 8'd1;
      end
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_rsp_result;
  assign busy        = r_busy;
  assign done_count  = r_done_count;
  assign bus_address = r_bus_address;
  assign bus_write   = r_bus_write;
  assign bus_wdata   = r_bus_wdata;

endmodule

// File: tb/tb_accel_bus_master.sv
// Bench for accel_bus_master: two instances (settle 2 and settle 0), each with a modelled
// peripheral, checked every cycle against a transaction schedule model plus literal expectations.
module tb_accel_bus_master;

  localparam int S0 = 2;
  localparam int S1 = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [1:0]       cmd_valid = 2'b00;
  logic [1:0]       rsp_ready = 2'b00;
  logic [1:0][7:0]  cmd_a = '0;
  logic [1:0][7:0]  cmd_b = '0;
  logic [1:0][2:0]  cmd_op = '0;
  logic [1:0]       cmd_ready;
  logic [1:0]       rsp_valid;
  logic [1:0][15:0] rsp_result;
  logic [1:0][3:0]  bus_address;
  logic [1:0]       bus_write;
  logic [1:0][7:0]  bus_wdata;
  logic [1:0][7:0]  bus_rdata;
  logic [1:0]       busy;
  logic [1:0][7:0]  done_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  accel_bus_master #(.SETTLE_CYCLES(S0)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_op(cmd_op[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]), .bus_address(bus_address[0]),
    .bus_write(bus_write[0]), .bus_wdata(bus_wdata[0]), .bus_rdata(bus_rdata[0]),
    .busy(busy[0]), .done_count(done_count[0])
  );

  accel_bus_master #(.SETTLE_CYCLES(S1)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_op(cmd_op[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]), .bus_address(bus_address[1]),
    .bus_write(bus_write[1]), .bus_wdata(bus_wdata[1]), .bus_rdata(bus_rdata[1]),
    .busy(busy[1]), .done_count(done_count[1])
  );

  function automatic int sc(input int d);
    return (d == 0) ? S0 : S1;
  endfunction

  // Peripheral arithmetic: op 1 subtract, op 2 multiply, anything else add; all 16-bit.
  function automatic logic [15:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [15:0] wa;
    logic [15:0] wb;
    wa = {8'h00, a};
    wb = {8'h00, b};
    case (op)
      3'd1:    return wa - wb;
      3'd2:    return wa * wb;
      default: return wa + wb;
    endcase
  endfunction

  logic [1:0][7:0] p_a = '0;
  logic [1:0][7:0] p_b = '0;
  logic [1:0][2:0] p_op = '0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (bus_write[d]) begin
        case (bus_address[d])
          4'h0:    p_a[d] <= bus_wdata[d];
          4'h1:    p_b[d] <= bus_wdata[d];
          4'h4:    p_op[d] <= bus_wdata[d][2:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus_rdata = '0;
    for (int d = 0; d < 2; d++) begin
      if (bus_address[d] == 4'h5) bus_rdata[d] = alu(p_a[d], p_b[d], p_op[d])[7:0];
      else if (bus_address[d] == 4'h6) bus_rdata[d] = alu(p_a[d], p_b[d], p_op[d])[15:8];
      else bus_rdata[d] = 8'h00;
    end
  end

  // Model: mk = cycles since the command was accepted (0 = idle); RESP at 6+settle.
  int             mk [2] = '{0, 0};
  logic [7:0]     m_a [2] = '{8'h00, 8'h00};
  logic [7:0]     m_b [2] = '{8'h00, 8'h00};
  logic [2:0]     m_op [2] = '{3'd0, 3'd0};
  logic [15:0]    m_res [2] = '{16'h0000, 16'h0000};
  logic [15:0]    m_last [2] = '{16'h0000, 16'h0000};
  logic [7:0]     m_done [2] = '{8'h00, 8'h00};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        mk[d] <= 0;
        m_last[d] <= 16'h0000;
        m_done[d] <= 8'h00;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (mk[d] == 0) begin
          if (cmd_valid[d]) begin
            mk[d] <= 1;
            m_a[d] <= cmd_a[d];
            m_b[d] <= cmd_b[d];
            m_op[d] <= cmd_op[d];
            m_res[d] <= alu(cmd_a[d], cmd_b[d], cmd_op[d]);
          end
        end else if (mk[d] < 6 + sc(d)) begin
          mk[d] <= mk[d] + 1;
        end else if (rsp_ready[d]) begin
          mk[d] <= 0;
          m_done[d] <= m_done[d] + 8'd1;
          m_last[d] <= m_res[d];
        end
      end
    end
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Expected {address, write, wdata, busy, cmd_ready, rsp_valid} for a cycle offset in the schedule.
  function automatic logic [15:0] exp_vec(input int k, input int s, input logic [7:0] a,
                                          input logic [7:0] b, input logic [2:0] op);
    logic [3:0] ad;
    logic       w;
    logic [7:0] wd;
    logic       bz;
    logic       rd;
    logic       vl;
    ad = 4'hF; w = 1'b0; wd = 8'h00; bz = 1'b1; rd = 1'b0; vl = 1'b0;
    if (k == 0) begin
      bz = 1'b0; rd = 1'b1;
    end else if (k == 1) begin
      ad = 4'h0; w = 1'b1; wd = a;
    end else if (k == 2) begin
      ad = 4'h1; w = 1'b1; wd = b;
    end else if (k == 3) begin
      ad = 4'h4; w = 1'b1; wd = {5'b00000, op};
    end else if (k <= 4 + s) begin
      ad = 4'h5;
    end else if (k == 5 + s) begin
      ad = 4'h6;
    end else begin
      vl = 1'b1;
    end
    return {ad, w, wd, bz, rd, vl};
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk("bus_ctl", d, {16'h0, bus_address[d], bus_write[d], bus_wdata[d], busy[d], cmd_ready[d], rsp_valid[d]},
          {16'h0, exp_vec(mk[d], sc(d), m_a[d], m_b[d], m_op[d])});
      chk("done_count", d, {24'h0, done_count[d]}, {24'h0, m_done[d]});
      if (mk[d] == 0) chk("rsp_result_idle", d, {16'h0, rsp_result[d]}, {16'h0, m_last[d]});
      else if (mk[d] == 6 + sc(d)) chk("rsp_result_resp", d, {16'h0, rsp_result[d]}, {16'h0, m_res[d]});
    end
  end

  task automatic send(input int d, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input int hold, input logic [15:0] exp_res, input int exp_lat, input logic [7:0] exp_done);
    int n;
    @(negedge clk);
    cmd_valid[d] = 1'b1; cmd_a[d] = a; cmd_b[d] = b; cmd_op[d] = op;
    @(posedge clk);
    #1 cmd_valid[d] = 1'b0;
    n = 1;
    while (!rsp_valid[d] && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency_edges", d, n, exp_lat);
    repeat (hold) @(negedge clk);
    chk("result_literal", d, {16'h0, rsp_result[d]}, {16'h0, exp_res});
    @(negedge clk);
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[d] = 1'b0;
    @(negedge clk);
    chk("done_literal", d, {24'h0, done_count[d]}, {24'h0, exp_done});
  endtask

  initial begin
    int n_hs;
    int cyc;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_address", 0, {28'h0, bus_address[0]}, 32'hF);
    chk("rst_result", 0, {16'h0, rsp_result[0]}, 32'h0);
    chk("rst_busy_write", 0, {30'h0, busy[0], bus_write[0]}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 0, {31'h0, cmd_ready[0]}, 32'h1);

    send(0, 8'h0C, 8'h05, 3'd2, 0, 16'h003C, 8, 8'h01);
    send(0, 8'hFF, 8'hFF, 3'd2, 5, 16'hFE01, 8, 8'h02);
    send(0, 8'h80, 8'h90, 3'd0, 1, 16'h0110, 8, 8'h03);
    send(1, 8'h03, 8'h05, 3'd1, 0, 16'hFFFE, 6, 8'h01);
    send(1, 8'h7F, 8'h01, 3'd7, 2, 16'h0080, 6, 8'h02);

    // Abort in WR_B: outputs must drop as soon as rst rises, without a clock edge.
    @(negedge clk);
    cmd_valid[0] = 1'b1; cmd_a[0] = 8'h11; cmd_b[0] = 8'h22; cmd_op[0] = 3'd2;
    @(posedge clk);
    #1 cmd_valid[0] = 1'b0;
    @(posedge clk);
    #2 chk("write_in_wr_b", 0, {31'h0, bus_write[0]}, 32'h1);
    rst = 1'b1;
    #1 chk("abort_write", 0, {31'h0, bus_write[0]}, 32'h0);
    chk("abort_busy", 0, {31'h0, busy[0]}, 32'h0);
    chk("abort_address", 0, {28'h0, bus_address[0]}, 32'hF);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    send(0, 8'h21, 8'h42, 3'd1, 0, 16'hFFDF, 8, 8'h01);

    // 256 back-to-back commands with cmd_valid held high and rsp_ready tied high.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rsp_ready[0] = 1'b1;
    cmd_valid[0] = 1'b1;
    n_hs = 0;
    cyc = 0;
    while (n_hs < 256 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      cmd_a[0] = 8'(cyc);
      cmd_b[0] = 8'(cyc * 7);
      cmd_op[0] = 3'(cyc % 3);
      if (rsp_valid[0]) begin
        n_hs++;
        if (n_hs == 256) begin
          chk("done_before_wrap", 0, {24'h0, done_count[0]}, 32'hFF);
          cmd_valid[0] = 1'b0;
        end
      end
    end
    chk("handshake_count", 0, n_hs, 256);
    @(negedge clk);
    chk("done_wrapped", 0, {24'h0, done_count[0]}, 32'h00);
    rsp_ready[0] = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
